// File: rtl/utlb_refill.sv
`timescale 1ns/1ps
// Fully-associative micro-TLB in front of the JTLB: registered lookup, single-outstanding refill,
// kseg0/kseg1 bypass and user-mode protection. Optional macro UTLB_PAGEMASK_EN adds per-entry pagemask.
module utlb_refill #(
   parameter  int ENTRIES = 4,
   parameter  int VPN2_W  = 19,
   parameter  int PFN_W   = 20,
   parameter  int ASID_W  = 8,
   localparam int HALF_W  = PFN_W + 5,
   localparam int ENT_W   = VPN2_W + ASID_W + 13 + 2*HALF_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ASID_W-1:0] asid,
   input  logic [2:0]        config_k0,
   input  logic              user_m,
   input  logic              flush,
   input  logic              kill,
   input  logic              lk_valid,
   output logic              lk_ready,
   input  logic [VPN2_W-1:0] lk_vpn2,
   input  logic              lk_odd,
   output logic              resp_valid,
   output logic              resp_found,
   output logic [PFN_W-1:0]  resp_pfn,
   output logic              resp_v,
   output logic              resp_d,
   output logic              resp_cached,
   output logic              jtlb_req,
   output logic [VPN2_W-1:0] jtlb_vpn2,
   input  logic              jtlb_ack,
   input  logic              jtlb_found,
   input  logic [ENT_W-1:0]  jtlb_entry,
   output logic [2:0]        state_dbg
);
   // Handshakes: a lookup transfers on an edge with lk_valid & lk_ready (lk_ready only in IDLE);
   // jtlb_req stays high until an edge with jtlb_ack, and an ack seen outside REQ/WAIT is ignored.
   localparam int PTR_W = $clog2(ENTRIES);

   typedef enum logic [2:0] {S_IDLE, S_LOOK, S_REQ, S_WAIT, S_RESP} state_t;
   state_t state, state_nx;

   logic [VPN2_W-1:0]  va_vpn2;
   logic               va_odd;
   logic               drop, killed;
   logic [PTR_W-1:0]   victim;
   logic               jq_found;
   logic [HALF_W-1:0]  jq_half;

   logic [ENTRIES-1:0] e_valid, e_g;
   logic [VPN2_W-1:0]  e_vpn2 [ENTRIES];
   logic [ASID_W-1:0]  e_asid [ENTRIES];
   logic [HALF_W-1:0]  e_even [ENTRIES];
   logic [HALF_W-1:0]  e_odd  [ENTRIES];

   // Half format is {pfn, c[2:0], d, v}, matching the JTLB entry layout.
   logic [VPN2_W-1:0]  j_vpn2;
   logic [ASID_W-1:0]  j_asid;
   logic               j_g;
   logic [11:0]        j_mask;
   logic [HALF_W-1:0]  j_even, j_odd, j_half;
   assign j_vpn2 = jtlb_entry[ENT_W-1 -: VPN2_W];
   assign j_asid = jtlb_entry[ENT_W-VPN2_W-1 -: ASID_W];
   assign j_g    = jtlb_entry[2*HALF_W+12];
   assign j_mask = jtlb_entry[2*HALF_W +: 12];
   assign j_even = jtlb_entry[HALF_W +: HALF_W];
   assign j_odd  = jtlb_entry[0 +: HALF_W];

   logic [ENTRIES-1:0] hit_vec;
   logic [HALF_W-1:0]  ent_half [ENTRIES];
   logic [HALF_W-1:0]  hit_half;

`ifdef UTLB_PAGEMASK_EN
   logic [11:0] e_mask [ENTRIES];
   logic [12:0] va_bits;
   assign va_bits = {va_vpn2[11:0], va_odd};

   // Even/odd select is the VA bit just above the mask; masked PFN bits come from the VA.
   function automatic logic [HALF_W-1:0] page_half(input logic [HALF_W-1:0] ev,
                                                   input logic [HALF_W-1:0] od,
                                                   input logic [11:0] mask,
                                                   input logic [12:0] vab);
      logic [12:0]       sel_1h;
      logic [HALF_W-1:0] h;
      sel_1h  = {1'b0, mask} + 13'd1;
      h       = (|(vab & sel_1h)) ? od : ev;
      h[16:5] = (h[16:5] & ~mask) | (vab[11:0] & mask);
      return h;
   endfunction

   assign j_half = page_half(j_even, j_odd, j_mask, va_bits);
`else
   logic unused_mask;
   assign unused_mask = ^j_mask;

   function automatic logic [HALF_W-1:0] page_half(input logic [HALF_W-1:0] ev,
                                                   input logic [HALF_W-1:0] od,
                                                   input logic odd);
      return odd ? od : ev;
   endfunction

   assign j_half = page_half(j_even, j_odd, va_odd);
`endif

   for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
      logic [VPN2_W-1:0] cmp_mask;
`ifdef UTLB_PAGEMASK_EN
      assign cmp_mask    = ~{{(VPN2_W-12){1'b0}}, e_mask[i]};
      assign ent_half[i] = page_half(e_even[i], e_odd[i], e_mask[i], va_bits);
`else
      assign cmp_mask    = '1;
      assign ent_half[i] = page_half(e_even[i], e_odd[i], va_odd);
`endif
      assign hit_vec[i] = e_valid[i] && ((e_vpn2[i] & cmp_mask) == (va_vpn2 & cmp_mask))
                          && (e_g[i] || (e_asid[i] == asid));
   end

   // At most one entry can match, so an OR of the matching halves is the hit mux.
   always_comb begin
      hit_half = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (hit_vec[i]) hit_half = hit_half | ent_half[i];
   end

   logic unmapped, kseg1, prot, ack_take, fill_en, accept;
   assign unmapped  = (va_vpn2[VPN2_W-1 -: 2] == 2'b10);
   assign kseg1     = (va_vpn2[VPN2_W-1 -: 3] == 3'b101);
   assign prot      = user_m && va_vpn2[VPN2_W-1];
   assign lk_ready  = (state == S_IDLE);
   assign accept    = lk_valid && lk_ready;
   assign jtlb_req  = (state == S_REQ) || (state == S_WAIT);
   assign jtlb_vpn2 = va_vpn2;
   assign state_dbg = state;
   assign ack_take  = jtlb_req && jtlb_ack;
   assign fill_en   = ack_take && jtlb_found && !drop && !flush;

   logic              resp_load, nx_found, nx_v, nx_d, nx_cached;
   logic [PFN_W-1:0]  nx_pfn;

   always_comb begin
      state_nx  = state;
      resp_load = 1'b0;
      nx_found  = 1'b0;
      nx_pfn    = '0;
      nx_v      = 1'b0;
      nx_d      = 1'b0;
      nx_cached = 1'b0;
      case (state)
         S_IDLE: if (lk_valid) state_nx = S_LOOK;
         S_LOOK: begin
            state_nx = S_IDLE;
            if (!kill) begin
               if (unmapped) begin
                  resp_load = 1'b1;
                  nx_found  = 1'b1;
                  nx_pfn    = PFN_W'({va_vpn2[15:0], va_odd});
                  nx_v      = 1'b1;
                  nx_d      = 1'b1;
                  nx_cached = !kseg1 && (config_k0 == 3'b011);
               end else if (|hit_vec) begin
                  resp_load = 1'b1;
                  nx_found  = 1'b1;
                  nx_pfn    = hit_half[HALF_W-1:5];
                  nx_cached = (hit_half[4:2] == 3'b011);
                  nx_d      = hit_half[1];
                  nx_v      = hit_half[0];
               end else if (prot) begin
                  resp_load = 1'b1;
               end else begin
                  state_nx = S_REQ;
               end
            end
         end
         S_REQ, S_WAIT: begin
            if (jtlb_ack) state_nx = (killed || kill) ? S_IDLE : S_RESP;
            else          state_nx = S_WAIT;
         end
         S_RESP: begin
            state_nx = S_IDLE;
            if (!kill) begin
               resp_load = 1'b1;
               nx_found  = jq_found;
               nx_pfn    = jq_half[HALF_W-1:5];
               nx_cached = (jq_half[4:2] == 3'b011);
               nx_d      = jq_half[1];
               nx_v      = jq_half[0];
            end
         end
         default: state_nx = S_IDLE;
      endcase
      if (prot) nx_v = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         va_vpn2     <= '0;
         va_odd      <= 1'b0;
         drop        <= 1'b0;
         killed      <= 1'b0;
         victim      <= '0;
         jq_found    <= 1'b0;
         jq_half     <= '0;
         e_valid     <= '0;
         resp_valid  <= 1'b0;
         resp_found  <= 1'b0;
         resp_pfn    <= '0;
         resp_v      <= 1'b0;
         resp_d      <= 1'b0;
         resp_cached <= 1'b0;
      end else begin
         state      <= state_nx;
         resp_valid <= resp_load;
         if (resp_load) begin
            resp_found  <= nx_found;
            resp_pfn    <= nx_pfn;
            resp_v      <= nx_v;
            resp_d      <= nx_d;
            resp_cached <= nx_cached;
         end
         if (accept) begin
            va_vpn2 <= lk_vpn2;
            va_odd  <= lk_odd;
            drop    <= 1'b0;
            killed  <= 1'b0;
         end else begin
            if (flush)            drop   <= 1'b1;
            if (kill && jtlb_req) killed <= 1'b1;
         end
         if (ack_take) begin
            jq_found <= jtlb_found;
            jq_half  <= jtlb_found ? j_half : '0;
         end
         // A flush on the fill edge wins: the victim slot stays invalid.
         if (flush)        e_valid         <= '0;
         else if (fill_en) e_valid[victim] <= 1'b1;
         if (fill_en) victim <= victim + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (fill_en) begin
         e_vpn2[victim] <= j_vpn2;
         e_asid[victim] <= j_asid;
         e_g[victim]    <= j_g;
         e_even[victim] <= j_even;
         e_odd[victim]  <= j_odd;
`ifdef UTLB_PAGEMASK_EN
         e_mask[victim] <= j_mask;
`endif
      end
   end
endmodule

// File: tb/tb_utlb_refill.sv
`timescale 1ns/1ps
// Directed bench for utlb_refill: bypass, hit, refill, eviction, flush, kill, protection and reset cases
// with hand-computed responses.
module tb_utlb_refill;
   localparam int ENTRIES = 4;
   localparam int VPN2_W  = 19;
   localparam int PFN_W   = 20;
   localparam int ASID_W  = 8;
   localparam int HALF_W  = PFN_W + 5;
   localparam int ENT_W   = VPN2_W + ASID_W + 13 + 2*HALF_W;

   logic              clk, rst;
   logic [ASID_W-1:0] asid;
   logic [2:0]        config_k0;
   logic              user_m, flush, kill;
   logic              lk_valid, lk_ready, lk_odd;
   logic [VPN2_W-1:0] lk_vpn2;
   logic              resp_valid, resp_found, resp_v, resp_d, resp_cached;
   logic [PFN_W-1:0]  resp_pfn;
   logic              jtlb_req, jtlb_ack, jtlb_found;
   logic [VPN2_W-1:0] jtlb_vpn2;
   logic [ENT_W-1:0]  jtlb_entry;
   logic [2:0]        state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   logic [23:0] exp_q[$];

   utlb_refill #(.ENTRIES(ENTRIES), .VPN2_W(VPN2_W), .PFN_W(PFN_W), .ASID_W(ASID_W)) dut (
      .clk(clk), .rst(rst), .asid(asid), .config_k0(config_k0), .user_m(user_m),
      .flush(flush), .kill(kill), .lk_valid(lk_valid), .lk_ready(lk_ready),
      .lk_vpn2(lk_vpn2), .lk_odd(lk_odd), .resp_valid(resp_valid), .resp_found(resp_found),
      .resp_pfn(resp_pfn), .resp_v(resp_v), .resp_d(resp_d), .resp_cached(resp_cached),
      .jtlb_req(jtlb_req), .jtlb_vpn2(jtlb_vpn2), .jtlb_ack(jtlb_ack), .jtlb_found(jtlb_found),
      .jtlb_entry(jtlb_entry), .state_dbg(state_dbg)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] er(input logic f, input logic v, input logic d,
                                      input logic c, input logic [19:0] pfn);
      return {f, v, d, c, pfn};
   endfunction

   function automatic logic [ENT_W-1:0] mk_entry(input logic [18:0] vpn2, input logic [7:0] a,
      input logic g, input logic [11:0] mask,
      input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
      input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
      return {vpn2, a, g, mask, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
   endfunction

   // driver tasks
   task automatic lookup_start(input logic [18:0] vpn2, input logic odd);
      lk_vpn2  = vpn2;
      lk_odd   = odd;
      lk_valid = 1'b1;
      tick();
      lk_valid = 1'b0;
   endtask

   task automatic get_resp(input string tag, input int max_wait, input logic [23:0] exp);
      int n;
      logic [23:0] obs;
      n = 0;
      exp_q.push_back(exp);
      while (!resp_valid && n < max_wait) begin
         tick();
         n++;
      end
      check_eq({tag, "_rv"}, resp_valid, 1);
      obs = {resp_found, resp_v, resp_d, resp_cached, resp_pfn};
      check_eq({tag, "_resp"}, obs, exp_q.pop_front());
      tick();
   endtask

   task automatic hit_lookup(input string tag, input logic [18:0] vpn2, input logic odd,
                             input logic [23:0] exp);
      lookup_start(vpn2, odd);
      tick();
      check_eq({tag, "_noreq"}, jtlb_req, 0);
      get_resp(tag, 0, exp);
   endtask

   // mode: 0 plain, 1 flush while waiting, 2 flush on the ack edge, 3 kill while waiting
   task automatic miss_lookup(input string tag, input logic [18:0] vpn2, input logic odd,
                              input logic fnd, input logic [ENT_W-1:0] ent, input int mode,
                              input logic [23:0] exp);
      logic seen;
      lookup_start(vpn2, odd);
      tick();
      check_eq({tag, "_req"}, jtlb_req, 1);
      check_eq({tag, "_jvpn2"}, jtlb_vpn2, vpn2);
      tick();
      if (mode == 1) begin
         flush = 1'b1;
         tick();
         flush = 1'b0;
      end
      if (mode == 3) begin
         kill = 1'b1;
         tick();
         kill = 1'b0;
         check_eq({tag, "_held"}, jtlb_req, 1);
      end
      tick();
      jtlb_ack   = 1'b1;
      jtlb_found = fnd;
      jtlb_entry = ent;
      if (mode == 2) flush = 1'b1;
      tick();
      jtlb_ack = 1'b0;
      flush    = 1'b0;
      if (mode == 3) begin
         check_eq({tag, "_ready"}, lk_ready, 1);
         seen = resp_valid;
         repeat (3) begin
            tick();
            seen = seen | resp_valid;
         end
         check_eq({tag, "_norv"}, seen, 0);
      end else begin
         get_resp(tag, 8, exp);
      end
   endtask

   initial begin
      logic [18:0] v;
      rst = 1'b1; asid = 8'h05; config_k0 = 3'b011; user_m = 1'b0; flush = 1'b0; kill = 1'b0;
      lk_valid = 1'b0; lk_vpn2 = '0; lk_odd = 1'b0;
      jtlb_ack = 1'b0; jtlb_found = 1'b0; jtlb_entry = '0;
      repeat (3) tick();
      rst = 1'b0;
      check_eq("rst_ready", lk_ready, 1);
      check_eq("rst_rv", resp_valid, 0);
      check_eq("rst_req", jtlb_req, 0);
      check_eq("rst_found", resp_found, 0);
      check_eq("rst_state", state_dbg, 0);

      hit_lookup("kseg1", 19'h50000, 1'b1, er(1, 1, 1, 0, 20'h00001));
      hit_lookup("kseg0", 19'h40ABC, 1'b1, er(1, 1, 1, 1, 20'h01579));
      config_k0 = 3'b010;
      hit_lookup("kseg0_nc", 19'h40ABC, 1'b0, er(1, 1, 1, 0, 20'h01578));
      config_k0 = 3'b011;

      miss_lookup("miss123", 19'h00123, 1'b0, 1'b1,
                  mk_entry(19'h00123, 8'h05, 1'b0, 12'h000, 20'hABCDE, 3'd3, 1'b1, 1'b1,
                           20'h12345, 3'd2, 1'b0, 1'b1), 0, er(1, 1, 1, 1, 20'hABCDE));
      hit_lookup("hit123e", 19'h00123, 1'b0, er(1, 1, 1, 1, 20'hABCDE));
      hit_lookup("hit123o", 19'h00123, 1'b1, er(1, 1, 0, 0, 20'h12345));
      asid = 8'h06;
      miss_lookup("asid_miss", 19'h00123, 1'b0, 1'b0, '0, 0, er(0, 0, 0, 0, 20'h0));
      asid = 8'h05;

      // 0x123 sits in slot 0; five global fills take slots 1,2,3,0,1
      for (int k = 0; k <= ENTRIES; k++) begin
         v = 19'h00200 + 19'(k);
         miss_lookup("fill", v, 1'b0, 1'b1,
                     mk_entry(v, 8'h00, 1'b1, 12'h000, 20'h20000 + 20'(k), 3'd2, 1'b0, 1'b1,
                              20'h0, 3'd0, 1'b0, 1'b0), 0, er(1, 1, 0, 0, 20'h20000 + 20'(k)));
      end
      miss_lookup("evict_1st", 19'h00200, 1'b0, 1'b0, '0, 0, er(0, 0, 0, 0, 20'h0));
      hit_lookup("keep_2nd", 19'h00201, 1'b0, er(1, 1, 0, 0, 20'h20001));
      hit_lookup("keep_last", 19'h00204, 1'b0, er(1, 1, 0, 0, 20'h20004));
      miss_lookup("evict_123", 19'h00123, 1'b0, 1'b0, '0, 0, er(0, 0, 0, 0, 20'h0));

      miss_lookup("flush_wait", 19'h00300, 1'b0, 1'b1,
                  mk_entry(19'h00300, 8'h05, 1'b0, 12'h000, 20'h30000, 3'd3, 1'b1, 1'b1,
                           20'h30001, 3'd3, 1'b1, 1'b1), 1, er(1, 1, 1, 1, 20'h30000));
      miss_lookup("flush_gone", 19'h00300, 1'b0, 1'b0, '0, 0, er(0, 0, 0, 0, 20'h0));
      miss_lookup("flush_all", 19'h00201, 1'b0, 1'b0, '0, 0, er(0, 0, 0, 0, 20'h0));
      miss_lookup("flush_fill", 19'h00301, 1'b0, 1'b1,
                  mk_entry(19'h00301, 8'h05, 1'b0, 12'h000, 20'h30100, 3'd3, 1'b1, 1'b1,
                           20'h30101, 3'd3, 1'b1, 1'b1), 2, er(1, 1, 1, 1, 20'h30100));
      miss_lookup("flush_fill_gone", 19'h00301, 1'b0, 1'b0, '0, 0, er(0, 0, 0, 0, 20'h0));

      miss_lookup("kill_wait", 19'h00400, 1'b0, 1'b1,
                  mk_entry(19'h00400, 8'h05, 1'b0, 12'h000, 20'h40000, 3'd3, 1'b1, 1'b1,
                           20'h40001, 3'd3, 1'b1, 1'b1), 3, er(0, 0, 0, 0, 20'h0));
      hit_lookup("kill_filled", 19'h00400, 1'b0, er(1, 1, 1, 1, 20'h40000));

      user_m = 1'b1;
      hit_lookup("user_k0", 19'h40000, 1'b0, er(1, 0, 1, 1, 20'h0));
      hit_lookup("user_k2", 19'h60000, 1'b0, er(0, 0, 0, 0, 20'h0));
      hit_lookup("user_kuseg", 19'h00400, 1'b0, er(1, 1, 1, 1, 20'h40000));
      user_m = 1'b0;

      lookup_start(19'h00500, 1'b0);
      tick();
      check_eq("rstmid_req", jtlb_req, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rstmid_req0", jtlb_req, 0);
      check_eq("rstmid_ready", lk_ready, 1);
      jtlb_ack   = 1'b1;
      jtlb_found = 1'b1;
      jtlb_entry = mk_entry(19'h00500, 8'h05, 1'b0, 12'h000, 20'h50000, 3'd3, 1'b1, 1'b1,
                            20'h50001, 3'd3, 1'b1, 1'b1);
      tick();
      jtlb_ack = 1'b0;
      check_eq("late_ack_rv", resp_valid, 0);
      check_eq("late_ack_state", state_dbg, 0);
      tick();
      check_eq("late_ack_rv2", resp_valid, 0);
      miss_lookup("post_rst", 19'h00400, 1'b0, 1'b0, '0, 0, er(0, 0, 0, 0, 20'h0));

`ifdef UTLB_PAGEMASK_EN
      miss_lookup("pm_even", 19'h00104, 1'b1, 1'b1,
                  mk_entry(19'h00104, 8'h05, 1'b0, 12'h003, 20'hABCDE, 3'd3, 1'b1, 1'b1,
                           20'h13579, 3'd2, 1'b0, 1'b1), 0, er(1, 1, 1, 1, 20'hABCDD));
      hit_lookup("pm_odd", 19'h00106, 1'b0, er(1, 1, 0, 0, 20'h13578));
      hit_lookup("pm_low", 19'h00105, 1'b0, er(1, 1, 1, 1, 20'hABCDE));
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
